// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W register file with registered, write-first reads,
// optional hardwired-zero register 0 and a per-register busy scoreboard used
// by decode to detect read-after-write hazards on in-flight results.
module regfile_scoreboard #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_BITS = 2,
  parameter int unsigned ZERO_REG  = 0
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic [ADDR_BITS-1:0] RS,
  input  logic [ADDR_BITS-1:0] RT,
  input  logic                 ReadEn,
  input  logic [ADDR_BITS-1:0] RD,
  input  logic [WIDTH-1:0]     WriteData,
  input  logic                 RegWrite,
  input  logic                 ReserveEn,
  input  logic [ADDR_BITS-1:0] ReserveAddr,
  output logic [WIDTH-1:0]     ReadRS,
  output logic [WIDTH-1:0]     ReadRT,
  output logic                 BusyRS,
  output logic                 BusyRT,
  output logic                 ReadValid,
  output logic [ADDR_BITS:0]   BusyCount
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam int unsigned CNT_W = ADDR_BITS + 1;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic [WIDTH-1:0] read_rs_q, read_rt_q;
  logic             busy_rs_q, busy_rt_q;
  logic             read_valid_q;
  logic [CNT_W-1:0] busy_count_q;
  logic [CNT_W-1:0] busy_count_d;

  // Next-state register contents and busy bits; reserve beats a same-cycle write.
  always_comb begin
    for (int a = 0; a < int'(DEPTH); a++) begin
      regs_d[a] = regs_q[a];
      busy_d[a] = busy_q[a];
      if (RegWrite && (RD == ADDR_BITS'(a))) begin
        regs_d[a] = WriteData;
        busy_d[a] = 1'b0;
      end
      if (ReserveEn && (ReserveAddr == ADDR_BITS'(a))) begin
        busy_d[a] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  // Population count of the next busy vector.
  always_comb begin
    busy_count_d = '0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      busy_count_d = busy_count_d + CNT_W'(busy_d[a]);
    end
  end

  // State and registered read ports; reads see next-state values (bypass).
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      for (int a = 0; a < int'(DEPTH); a++) begin
        regs_q[a] <= '0;
      end
      busy_q       <= '0;
      read_rs_q    <= '0;
      read_rt_q    <= '0;
      busy_rs_q    <= 1'b0;
      busy_rt_q    <= 1'b0;
      read_valid_q <= 1'b0;
      busy_count_q <= '0;
    end else begin
      for (int a = 0; a < int'(DEPTH); a++) begin
        regs_q[a] <= regs_d[a];
      end
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      read_valid_q <= ReadEn;
      if (ReadEn) begin
        read_rs_q <= regs_d[RS];
        read_rt_q <= regs_d[RT];
        busy_rs_q <= busy_d[RS];
        busy_rt_q <= busy_d[RT];
      end
    end
  end

  assign ReadRS    = read_rs_q;
  assign ReadRT    = read_rt_q;
  assign BusyRS    = busy_rs_q;
  assign BusyRT    = busy_rt_q;
  assign ReadValid = read_valid_q;
  assign BusyCount = busy_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one instance with ZERO_REG=0 and one
// with ZERO_REG=1, driven by the same stimulus.
module tb_regfile_scoreboard;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned ADDR_BITS = 2;

  logic                 Clock = 1'b0;
  logic                 ResetN;
  logic [ADDR_BITS-1:0] RS, RT, RD, ReserveAddr;
  logic                 ReadEn, RegWrite, ReserveEn;
  logic [WIDTH-1:0]     WriteData;

  logic [WIDTH-1:0]   rs_n, rt_n, rs_z, rt_z;
  logic               brs_n, brt_n, brs_z, brt_z;
  logic               vld_n, vld_z;
  logic [ADDR_BITS:0] cnt_n, cnt_z;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  regfile_scoreboard #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .ZERO_REG(0)) u_dut (
    .Clock(Clock), .ResetN(ResetN), .RS(RS), .RT(RT), .ReadEn(ReadEn), .RD(RD),
    .WriteData(WriteData), .RegWrite(RegWrite), .ReserveEn(ReserveEn),
    .ReserveAddr(ReserveAddr), .ReadRS(rs_n), .ReadRT(rt_n), .BusyRS(brs_n),
    .BusyRT(brt_n), .ReadValid(vld_n), .BusyCount(cnt_n)
  );

  regfile_scoreboard #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .ZERO_REG(1)) u_dut_z (
    .Clock(Clock), .ResetN(ResetN), .RS(RS), .RT(RT), .ReadEn(ReadEn), .RD(RD),
    .WriteData(WriteData), .RegWrite(RegWrite), .ReserveEn(ReserveEn),
    .ReserveAddr(ReserveAddr), .ReadRS(rs_z), .ReadRT(rt_z), .BusyRS(brs_z),
    .BusyRT(brt_z), .ReadValid(vld_z), .BusyCount(cnt_z)
  );

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    ReadEn = 1'b0; RegWrite = 1'b0; ReserveEn = 1'b0;
    RS = '0; RT = '0; RD = '0; ReserveAddr = '0; WriteData = '0;
  endtask

  task automatic test_reset();
    idle();
    ResetN = 1'b0;
    ReadEn = 1'b1; RegWrite = 1'b1; RD = 2'd1; WriteData = 16'h7777;
    step();
    checks++;
    if ({rs_n, rt_n, brs_n, brt_n, vld_n, cnt_n} !== '0) begin
      errors++; $display("FAIL reset_outputs_n got %h/%h b%b%b v%b c%0d want all 0",
                         rs_n, rt_n, brs_n, brt_n, vld_n, cnt_n);
    end
    checks++;
    if ({rs_z, rt_z, brs_z, brt_z, vld_z, cnt_z} !== '0) begin
      errors++; $display("FAIL reset_outputs_z got %h/%h b%b%b v%b c%0d want all 0",
                         rs_z, rt_z, brs_z, brt_z, vld_z, cnt_z);
    end
    idle();
    ResetN = 1'b1;
    for (int a = 0; a < 4; a++) begin
      ReadEn = 1'b1; RS = 2'(a); RT = 2'(3 - a);
      step();
      checks++;
      if (rs_n !== 16'h0 || rt_n !== 16'h0 || brs_n !== 1'b0 || brt_n !== 1'b0 ||
          vld_n !== 1'b1 || cnt_n !== 3'd0) begin
        errors++; $display("FAIL reset_read_%0d got %h/%h b%b%b v%b c%0d want 0/0 b00 v1 c0",
                           a, rs_n, rt_n, brs_n, brt_n, vld_n, cnt_n);
      end
    end
    ReadEn = 1'b0;
    step();
    checks++;
    if (vld_n !== 1'b0) begin
      errors++; $display("FAIL reset_valid_drop got %b want 0", vld_n);
    end
  endtask

  task automatic test_bypass();
    idle();
    RegWrite = 1'b1; RD = 2'd2; WriteData = 16'hBEEF;
    ReadEn = 1'b1; RS = 2'd2; RT = 2'd0;
    step();
    checks++;
    if (rs_n !== 16'hBEEF || rt_n !== 16'h0 || vld_n !== 1'b1) begin
      errors++; $display("FAIL bypass_rs got %h/%h v%b want beef/0000 v1", rs_n, rt_n, vld_n);
    end
    RegWrite = 1'b0; RS = 2'd0; RT = 2'd2;
    step();
    checks++;
    if (rt_n !== 16'hBEEF || rs_n !== 16'h0) begin
      errors++; $display("FAIL read_rt_after got %h/%h want 0000/beef", rs_n, rt_n);
    end
    // Hold behaviour with ReadEn low, while writing a different value.
    ReadEn = 1'b0; RegWrite = 1'b1; RD = 2'd2; WriteData = 16'h1111;
    step();
    checks++;
    if (rt_n !== 16'hBEEF || vld_n !== 1'b0) begin
      errors++; $display("FAIL read_hold got %h v%b want beef v0", rt_n, vld_n);
    end
    // Back-to-back reads with a write each cycle.
    RD = 2'd3; WriteData = 16'h2222; ReadEn = 1'b1; RS = 2'd2; RT = 2'd3;
    step();
    checks++;
    if (rs_n !== 16'h1111 || rt_n !== 16'h2222 || vld_n !== 1'b1) begin
      errors++; $display("FAIL b2b_0 got %h/%h v%b want 1111/2222 v1", rs_n, rt_n, vld_n);
    end
    RD = 2'd2; WriteData = 16'h3333; RS = 2'd3; RT = 2'd2;
    step();
    checks++;
    if (rs_n !== 16'h2222 || rt_n !== 16'h3333 || vld_n !== 1'b1) begin
      errors++; $display("FAIL b2b_1 got %h/%h v%b want 2222/3333 v1", rs_n, rt_n, vld_n);
    end
  endtask

  task automatic test_reserve();
    idle();
    ReserveEn = 1'b1; ReserveAddr = 2'd1;
    step();
    checks++;
    if (cnt_n !== 3'd1) begin
      errors++; $display("FAIL reserve_cnt1 got %0d want 1", cnt_n);
    end
    ReserveAddr = 2'd3;
    step();
    checks++;
    if (cnt_n !== 3'd2) begin
      errors++; $display("FAIL reserve_cnt2 got %0d want 2", cnt_n);
    end
    ReserveEn = 1'b0; ReadEn = 1'b1; RS = 2'd1; RT = 2'd2;
    step();
    checks++;
    if (brs_n !== 1'b1 || brt_n !== 1'b0 || cnt_n !== 3'd2) begin
      errors++; $display("FAIL reserve_busy_read got b%b%b c%0d want b10 c2", brs_n, brt_n, cnt_n);
    end
    RegWrite = 1'b1; RD = 2'd1; WriteData = 16'h0042; RS = 2'd1; RT = 2'd3;
    step();
    checks++;
    if (rs_n !== 16'h0042 || brs_n !== 1'b0 || brt_n !== 1'b1 || cnt_n !== 3'd1) begin
      errors++; $display("FAIL write_clears_busy got %h b%b%b c%0d want 0042 b01 c1",
                         rs_n, brs_n, brt_n, cnt_n);
    end
  endtask

  task automatic test_same_cycle();
    idle();
    ReserveEn = 1'b1; ReserveAddr = 2'd3;
    RegWrite = 1'b1; RD = 2'd3; WriteData = 16'h1234;
    ReadEn = 1'b1; RS = 2'd1; RT = 2'd3;
    step();
    checks++;
    if (rt_n !== 16'h1234 || brt_n !== 1'b1 || brs_n !== 1'b0 || cnt_n !== 3'd1) begin
      errors++; $display("FAIL reserve_write_same got %h b%b%b c%0d want 1234 b01 c1",
                         rt_n, brs_n, brt_n, cnt_n);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    ResetN = 1'b0;
    step();
    ResetN = 1'b1;
    RegWrite = 1'b1; RD = 2'd0; WriteData = 16'hFFFF;
    ReserveEn = 1'b1; ReserveAddr = 2'd0;
    ReadEn = 1'b1; RS = 2'd0; RT = 2'd0;
    step();
    checks++;
    if (rs_z !== 16'h0 || rt_z !== 16'h0 || brs_z !== 1'b0 || brt_z !== 1'b0 || cnt_z !== 3'd0) begin
      errors++; $display("FAIL zero_reg_same got %h/%h b%b%b c%0d want 0/0 b00 c0",
                         rs_z, rt_z, brs_z, brt_z, cnt_z);
    end
    checks++;
    if (rs_n !== 16'hFFFF || rt_n !== 16'hFFFF || brs_n !== 1'b1 || cnt_n !== 3'd1) begin
      errors++; $display("FAIL normal_r0 got %h/%h b%b c%0d want ffff/ffff b1 c1",
                         rs_n, rt_n, brs_n, cnt_n);
    end
    RegWrite = 1'b0; ReserveEn = 1'b0;
    step();
    checks++;
    if (rs_z !== 16'h0 || brs_z !== 1'b0 || cnt_z !== 3'd0) begin
      errors++; $display("FAIL zero_reg_later got %h b%b c%0d want 0 b0 c0", rs_z, brs_z, cnt_z);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    ReserveEn = 1'b1;
    for (int a = 0; a < 3; a++) begin
      ReserveAddr = 2'(a);
      step();
    end
    checks++;
    if (cnt_n !== 3'd3 || cnt_z !== 3'd2) begin
      errors++; $display("FAIL reserve_three got n%0d z%0d want n3 z2", cnt_n, cnt_z);
    end
    ReserveAddr = 2'd3; RegWrite = 1'b1; RD = 2'd1; WriteData = 16'h5555;
    step();
    checks++;
    if (cnt_n !== 3'd3 || cnt_z !== 3'd2) begin
      errors++; $display("FAIL reserve_all_write got n%0d z%0d want n3 z2", cnt_n, cnt_z);
    end
    ReadEn = 1'b1; RS = 2'd1; RT = 2'd3; ReserveEn = 1'b0; RegWrite = 1'b0;
    step();
    checks++;
    if (rs_n !== 16'h5555 || brs_n !== 1'b0 || brt_n !== 1'b1 || cnt_n !== 3'd4 - 3'd1) begin
      errors++; $display("FAIL pre_reset_read got %h b%b%b c%0d want 5555 b01 c3",
                         rs_n, brs_n, brt_n, cnt_n);
    end
    ResetN = 1'b0; RegWrite = 1'b1; RD = 2'd1; WriteData = 16'hAAAA;
    ReserveEn = 1'b1; ReserveAddr = 2'd2;
    step();
    checks++;
    if ({rs_n, rt_n, brs_n, brt_n, vld_n, cnt_n} !== '0 ||
        {rs_z, rt_z, brs_z, brt_z, vld_z, cnt_z} !== '0) begin
      errors++; $display("FAIL mid_reset got n %h/%h b%b%b v%b c%0d z c%0d want all 0",
                         rs_n, rt_n, brs_n, brt_n, vld_n, cnt_n, cnt_z);
    end
    ResetN = 1'b1; RegWrite = 1'b0; ReserveEn = 1'b0;
    ReadEn = 1'b1; RS = 2'd1; RT = 2'd3;
    step();
    checks++;
    if (rs_n !== 16'h0 || rt_n !== 16'h0 || brs_n !== 1'b0 || brt_n !== 1'b0 ||
        vld_n !== 1'b1 || cnt_n !== 3'd0) begin
      errors++; $display("FAIL post_reset_r1r3 got %h/%h b%b%b v%b c%0d want 0/0 b00 v1 c0",
                         rs_n, rt_n, brs_n, brt_n, vld_n, cnt_n);
    end
    RS = 2'd0; RT = 2'd2;
    step();
    checks++;
    if (rs_n !== 16'h0 || rt_n !== 16'h0 || brs_n !== 1'b0 || brt_n !== 1'b0 || cnt_n !== 3'd0) begin
      errors++; $display("FAIL post_reset_r0r2 got %h/%h b%b%b c%0d want 0/0 b00 c0",
                         rs_n, rt_n, brs_n, brt_n, cnt_n);
    end
  endtask

  initial begin
    ResetN = 1'b0;
    idle();
    test_reset();
    test_bypass();
    test_reserve();
    test_same_cycle();
    test_zero_reg();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the 4×16 register file. It keeps two read ports and one write port, and adds registered reads with write-to-read bypass and an optional hardwired-zero register 0. It also adds a per-register busy scoreboard, which the control unit uses to detect read-after-write hazards on in-flight results. It sits between decode (read/reserve) and writeback (write) in the CPU datapath.

## Interface
Parameters:
- WIDTH, 16, data width of each register.
- ADDR_BITS, 2, register address width; DEPTH = 2**ADDR_BITS.
- ZERO_REG, 0, when 1 register 0 always reads 0, ignores writes and is never busy.

Ports:
- Clock  in  1  single clock; all state updates on rising edge.
- ResetN  in  1  reset, synchronous, active-low.
- RS  in  ADDR_BITS  read address, port S.
- RT  in  ADDR_BITS  read address, port T.
- ReadEn  in  1  sample RS/RT this cycle.
- RD  in  ADDR_BITS  write address.
- WriteData  in  WIDTH  write data.
- RegWrite  in  1  write enable; also clears busy[RD].
- ReserveEn  in  1  mark ReserveAddr busy (result pending).
- ReserveAddr  in  ADDR_BITS  register to reserve.
- ReadRS  out  WIDTH  registered read data, port S.
- ReadRT  out  WIDTH  registered read data, port T.
- BusyRS  out  1  registered busy flag of sampled RS.
- BusyRT  out  1  registered busy flag of sampled RT.
- ReadValid  out  1  ReadRS/ReadRT/BusyRS/BusyRT updated by a ReadEn one cycle earlier.
- BusyCount  out  ADDR_BITS+1  registered count of busy registers.

## Operation
- Reset (ResetN=0 at an edge):
  - All DEPTH registers and all busy bits go to 0.
  - ReadRS, ReadRT, BusyRS, BusyRT, ReadValid and BusyCount all go to 0.
  - Reset overrides any concurrent write, reserve or read. Reset mid-sequence discards all pending reservations.
- Write: RegWrite=1 at an edge sets Registers[RD] <= WriteData and clears busy[RD].
- Reserve: ReserveEn=1 at an edge sets busy[ReserveAddr].
- Reserve and write to the same address in one cycle: the data is written and busy ends up 1 (the reserve, as the newer producer, wins).
- Next-state values, per address a:
  - reg_next[a] = WriteData if (RegWrite && RD==a), else Registers[a].
  - busy_next[a] = 1 if (ReserveEn && ReserveAddr==a); else 0 if (RegWrite && RD==a); else busy[a].
- Read: ReadEn=1 at an edge latches:
  - ReadRS <= reg_next[RS] and ReadRT <= reg_next[RT]. A same-cycle write is bypassed (write-first).
  - BusyRS <= busy_next[RS] and BusyRT <= busy_next[RT].
  - ReadValid <= 1.
- ReadEn=0 at an edge: ReadRS, ReadRT, BusyRS and BusyRT hold their values; ReadValid <= 0.
- RS==RT is legal; both ports return identical values.
- ZERO_REG=1:
  - Writes to address 0 are dropped; Registers[0] stays 0.
  - Reserves of address 0 are dropped; busy[0] stays 0.
  - Reads of address 0 return data 0 and busy 0, including when RegWrite targets RD=0 in the same cycle.
- BusyCount <= popcount(busy_next) every edge, range 0..DEPTH. Width ADDR_BITS+1 holds DEPTH without wrap.
- All address inputs are full-range; no out-of-range case exists.

## Timing
- Read latency: 1 cycle (address at edge N, data valid after edge N, ReadValid high for that cycle).
- Write-to-read: a read sampled in the same cycle as a write returns the new data. There is no extra cycle of visibility delay.
- Busy set or clear is visible to a read sampled in the same cycle (busy_next semantics).
- Back-to-back reads every cycle are supported; throughput is 1 read pair per cycle alongside 1 write and 1 reserve.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Reset, then read all addresses: ReadRS/ReadRT = 0, BusyRS/BusyRT = 0, BusyCount = 0, ReadValid = 1 one cycle after each ReadEn.
- Write 16'hBEEF to R2 with ReadEn=1, RS=2 in the same cycle: next cycle ReadRS = 16'hBEEF (bypass). Read RT=2 one cycle later: ReadRT = 16'hBEEF.
- Reserve R1, then reserve R3 the next cycle: BusyCount goes 1 then 2, and a read of R1 gives BusyRS=1. Then RegWrite R1 = 16'h0042: busy[1] clears, BusyCount = 1, and a read of R1 gives 16'h0042 with BusyRS=0.
- Same-cycle ReserveEn and RegWrite on R3 with data 16'h1234: read R3 returns 16'h1234 with BusyRT=1, and BusyCount is unchanged for R3.
- ZERO_REG=1, write 16'hFFFF to R0 and reserve R0: read R0 returns 0 with busy 0, and BusyCount stays 0.
- Reserve R0..R3 and write R1 = 16'h5555, then hold ResetN=0 for one cycle while RegWrite=1: all registers and busy bits are 0, all outputs are 0, and the write is dropped.
